// File: rtl/state2_pkg.sv
// Shared definitions for the state2 sequencer/arbiter: FSM output codes,
// drive patterns and the controller state encoding.
package state2_pkg;

    localparam logic [2:0] CODE_IDLE  = 3'b000;
    localparam logic [2:0] CODE_S1    = 3'b100;
    localparam logic [2:0] CODE_S2    = 3'b010;
    localparam logic [2:0] CODE_ERROR = 3'b111;

    localparam logic [1:0] DRV_IDLE = 2'b00;
    localparam logic [1:0] DRV_P12  = 2'b11;
    localparam logic [1:0] DRV_P3   = 2'b10;

    typedef enum logic [2:0] {
        C_IDLE    = 3'd0,
        P1        = 3'd1,
        P2        = 3'd2,
        P3        = 3'd3,
        C_DONE    = 3'd4,
        C_RECOVER = 3'd5,
        C_FAIL    = 3'd6
    } ctrl_state_t;

    // {i1,i2} presented to the FSM while the controller sits in a state
    function automatic logic [1:0] drive_of(input ctrl_state_t st);
        case (st)
            P1, P2:  drive_of = DRV_P12;
            P3:      drive_of = DRV_P3;
            default: drive_of = DRV_IDLE;
        endcase
    endfunction

    // {o1,o2,err} that lets the controller leave a state
    function automatic logic [2:0] expect_of(input ctrl_state_t st);
        case (st)
            P1:      expect_of = CODE_S1;
            P2:      expect_of = CODE_S2;
            default: expect_of = CODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/state2_seq_arb_rr_arb2.sv
// Two-request round-robin arbiter; r_ptr names the requester favoured on a tie
// and moves to the other side of whoever was just served.
module rr_arb2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_idx,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~i_upd_idx;
        end
    end

    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/state2_seq_arb.sv
// Sequencer + 2-way round-robin arbiter walking the state2 FSM through
// IDLE->S1->S2->IDLE, with recovery, retries and a saturating error count.
module state2_seq_arb
    import state2_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             fsm_i1,
    output logic             fsm_i2,
    input  logic             fsm_o1,
    input  logic             fsm_o2,
    input  logic             fsm_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RTRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRY);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    logic [TMR_W-1:0]  r_timer;
    logic [RTRY_W-1:0] r_retry;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [1:0]        r_gnt;
    logic [1:0]        r_drive;
    logic              r_done;
    logic              r_fail;

    logic [1:0] w_gnt_next;
    logic [1:0] w_drive_next;
    logic [1:0] w_arb_gnt;
    logic [2:0] w_obs;
    logic       w_done_next;
    logic       w_fail_next;
    logic       w_err_event;
    logic       w_retry_inc;
    logic       w_grant;
    logic       w_match;
    logic       w_timeout;
    logic       w_arb_upd;

    assign w_obs     = {fsm_o1, fsm_o2, fsm_err};
    assign w_match   = (w_obs == expect_of(r_state));
    assign w_timeout = (r_timer == TMR_LAST);
    assign w_arb_upd = (r_state == C_DONE) || (r_state == C_FAIL);

    rr_arb2 u_arb (
        .clk       (clk),
        .nrst      (nrst),
        .i_req     (req),
        .i_upd     (w_arb_upd),
        .i_upd_idx (r_gnt[1]),
        .o_gnt     (w_arb_gnt)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_event  = 1'b0;
        w_retry_inc  = 1'b0;
        w_grant      = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (|req) begin
                    w_grant      = 1'b1;
                    w_state_next = P1;
                end
            end
            P1, P2, P3: begin
                // err wins over everything; other codes are tolerated until the timer runs out
                if (fsm_err || (!w_match && w_timeout)) begin
                    w_err_event  = 1'b1;
                    w_state_next = C_RECOVER;
                end else if (w_match) begin
                    case (r_state)
                        P1:      w_state_next = P2;
                        P2:      w_state_next = P3;
                        default: w_state_next = C_DONE;
                    endcase
                end
            end
            C_RECOVER: begin
                if (w_match) begin
                    if (r_retry < RTRY_MAX) begin
                        w_retry_inc  = 1'b1;
                        w_state_next = P1;
                    end else begin
                        w_state_next = C_FAIL;
                    end
                end else if (w_timeout) begin
                    w_err_event  = 1'b1;
                    w_state_next = C_FAIL;
                end
            end
            C_DONE, C_FAIL: w_state_next = C_IDLE;
            default:        w_state_next = C_IDLE;
        endcase
    end

    always_comb begin
        w_drive_next = drive_of(w_state_next);
        w_done_next  = (w_state_next == C_DONE);
        w_fail_next  = (w_state_next == C_FAIL);
        case (r_state)
            C_IDLE:                w_gnt_next = w_grant ? w_arb_gnt : 2'b00;
            P1, P2, P3, C_RECOVER: w_gnt_next = r_gnt;
            default:               w_gnt_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_gnt     <= 2'b00;
            r_drive   <= DRV_IDLE;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_timer   <= '0;
            r_retry   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_gnt   <= w_gnt_next;
            r_drive <= w_drive_next;
            r_done  <= w_done_next;
            r_fail  <= w_fail_next;
            if (w_state_next != r_state) begin
                r_timer <= '0;
            end else if (r_timer != TMR_LAST) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_grant) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_err_event && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign gnt     = r_gnt;
    assign busy    = |r_gnt;
    assign done    = r_done;
    assign fail    = r_fail;
    assign fsm_i1  = r_drive[1];
    assign fsm_i2  = r_drive[0];
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_state2_seq_arb.sv
// Bench for state2_seq_arb: behavioural state2 FSM with error/freeze knobs,
// a completion scoreboard and cycle-exact checks around each scenario.
module tb_state2_seq_arb;

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       busy, done, fail;
    logic       fsm_i1, fsm_i2;
    logic       fsm_o1, fsm_o2, fsm_err;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       is_fail;
        logic [1:0] gnt;
        logic [7:0] cnt;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    // FSM model: IDLE-11->S1-11->S2-10->IDLE, ERROR-00->IDLE
    logic [2:0] m_cs;
    logic [1:0] m_drv;
    logic       freeze = 1'b0;
    int         inj_req = 0;
    int         inj_taken = 0;
    logic [1:0] nom_drv [6];

    always #5 clk = ~clk;

    state2_seq_arb dut (
        .clk     (clk),
        .nrst    (nrst),
        .req     (req),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .fail    (fail),
        .fsm_i1  (fsm_i1),
        .fsm_i2  (fsm_i2),
        .fsm_o1  (fsm_o1),
        .fsm_o2  (fsm_o2),
        .fsm_err (fsm_err),
        .err_cnt (err_cnt)
    );

    assign m_drv = {fsm_i1, fsm_i2};
    assign {fsm_o1, fsm_o2, fsm_err} = freeze ? 3'b000 : m_cs;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_cs <= 3'b000;
        end else if (m_cs == 3'b100 && m_drv == 2'b11 && inj_taken < inj_req) begin
            m_cs      <= 3'b111;
            inj_taken <= inj_taken + 1;
        end else begin
            case (m_cs)
                3'b000:  if (m_drv == 2'b11) m_cs <= 3'b100;
                3'b100:  if (m_drv == 2'b11) m_cs <= 3'b010;
                         else if (m_drv == 2'b00) m_cs <= 3'b000;
                3'b010:  if (m_drv == 2'b10 || m_drv == 2'b00) m_cs <= 3'b000;
                default: if (m_drv == 2'b00) m_cs <= 3'b000;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic sb_push(input logic f, input logic [1:0] g, input logic [7:0] c);
        sb_t e;
        e.is_fail = f;
        e.gnt     = g;
        e.cnt     = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_gnt(input int max_cyc);
        int n = 0;
        while (gnt == 2'b00 && n < max_cyc) begin
            tick();
            n++;
        end
        if (gnt == 2'b00) chk("wait_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pulse(input int max_cyc);
        int n = 0;
        while (!(done || fail) && n < max_cyc) begin
            tick();
            n++;
        end
        if (!(done || fail)) chk("wait_pulse_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_sb_empty(input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) chk("wait_sb_timeout", 32'd0, 32'd1);
    endtask

    // completion monitor plus per-cycle invariants
    always @(negedge clk) begin
        if (nrst) begin
            chk("gnt_onehot_or_zero", 32'($countones(gnt) <= 1), 32'd1);
            chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
            chk("done_fail_excl", 32'(done & fail), 32'd0);
            if (done || fail) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_pulse", 32'({done, fail}), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("txn: gnt=%b done=%b fail=%b err_cnt=%0d", gnt, done, fail, err_cnt);
                    chk("sb_done", 32'(done), 32'(!mon_e.is_fail));
                    chk("sb_fail", 32'(fail), 32'(mon_e.is_fail));
                    chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
                    chk("sb_err_cnt", 32'(err_cnt), 32'(mon_e.cnt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nom_drv = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
        nrst = 1'b0;
        req  = 2'b00;
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_fail", 32'({done, fail}), 32'd0);
        chk("rst_fsm_i", 32'({fsm_i1, fsm_i2}), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        // nominal walk
        req = 2'b01;
        sb_push(1'b0, 2'b01, 8'd0);
        wait_gnt(20);
        chk("nom_gnt_c0", 32'(gnt), 32'h1);
        for (int k = 0; k < 6; k++) begin
            chk("nom_fsm_i", 32'({fsm_i1, fsm_i2}), 32'(nom_drv[k]));
            chk("nom_done", 32'(done), 32'(k == 5));
            chk("nom_err_cnt", 32'(err_cnt), 32'd0);
            if (k == 5) req = 2'b00;
            tick();
        end
        chk("nom_gnt_c6", 32'(gnt), 32'd0);
        chk("nom_busy_c6", 32'(busy), 32'd0);
        settle(3);

        // arbitration with both requests held from reset
        req = 2'b11;
        do_reset();
        sb_push(1'b0, 2'b01, 8'd0);
        sb_push(1'b0, 2'b10, 8'd0);
        sb_push(1'b0, 2'b01, 8'd0);
        wait_gnt(20);
        chk("arb_first", 32'(gnt), 32'h1);
        wait_pulse(40);
        tick();
        chk("arb_gap", 32'(gnt), 32'd0);
        tick();
        chk("arb_second", 32'(gnt), 32'h2);
        wait_pulse(40);
        tick();
        tick();
        chk("arb_third", 32'(gnt), 32'h1);
        wait_sb_empty(40);
        req = 2'b00;
        settle(3);

        // single injected error in P2
        do_reset();
        inj_req = inj_req + 1;
        req = 2'b01;
        sb_push(1'b0, 2'b01, 8'd1);
        wait_gnt(20);
        settle(2);
        chk("serr_obs_err_c2", 32'(fsm_err), 32'd1);
        tick();
        chk("serr_drive_c3", 32'({fsm_i1, fsm_i2}), 32'd0);
        chk("serr_err_cnt_c3", 32'(err_cnt), 32'd1);
        wait_sb_empty(60);
        req = 2'b00;
        settle(3);

        // persistent error on every attempt
        do_reset();
        inj_req = inj_req + 3;
        req = 2'b10;
        sb_push(1'b1, 2'b10, 8'd3);
        wait_gnt(20);
        chk("perr_gnt", 32'(gnt), 32'h2);
        wait_pulse(80);
        chk("perr_fail", 32'(fail), 32'd1);
        chk("perr_done", 32'(done), 32'd0);
        chk("perr_obs_idle", 32'({fsm_o1, fsm_o2, fsm_err}), 32'd0);
        chk("perr_err_cnt", 32'(err_cnt), 32'd3);
        req = 2'b00;
        tick();
        chk("perr_fail_1cyc", 32'(fail), 32'd0);
        chk("perr_gnt_after", 32'(gnt), 32'd0);
        settle(3);

        // FSM outputs frozen at 000 while in P1
        do_reset();
        freeze = 1'b1;
        req = 2'b01;
        sb_push(1'b0, 2'b01, 8'd1);
        wait_gnt(20);
        settle(7);
        chk("stuck_drive_c7", 32'({fsm_i1, fsm_i2}), 32'h3);
        chk("stuck_err_cnt_c7", 32'(err_cnt), 32'd0);
        tick();
        chk("stuck_drive_c8", 32'({fsm_i1, fsm_i2}), 32'd0);
        chk("stuck_err_cnt_c8", 32'(err_cnt), 32'd1);
        freeze = 1'b0;
        wait_sb_empty(60);
        req = 2'b00;
        settle(3);

        // reset in the middle of a walk
        req = 2'b01;
        wait_gnt(20);
        settle(2);
        chk("rmw_err_cnt_before", 32'(err_cnt), 32'd1);
        nrst = 1'b0;
        #1;
        chk("rmw_gnt", 32'(gnt), 32'd0);
        chk("rmw_fsm_i", 32'({fsm_i1, fsm_i2}), 32'd0);
        chk("rmw_err_cnt", 32'(err_cnt), 32'd0);
        chk("rmw_done_fail", 32'({done, fail}), 32'd0);
        req = 2'b00;
        settle(2);
        nrst = 1'b1;
        settle(5);
        req = 2'b01;
        sb_push(1'b0, 2'b01, 8'd0);
        wait_gnt(20);
        chk("rmw_regrant", 32'(gnt), 32'h1);
        wait_sb_empty(40);
        req = 2'b00;
        settle(3);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
